// File: rtl/axis_batch_receiver_pkg.sv
// -----------------------------------------------------------------------------
// axis_batch_receiver_pkg
// Shared training constants (character width, characters per sample, samples
// per batch) plus a width helper used by the batch receiver files.
// No ports.
// -----------------------------------------------------------------------------
package axis_batch_receiver_pkg;

    localparam int TRAIN_CHAR_LEN   = 8;
    localparam int TRAIN_N          = 4;
    localparam int TRAIN_BATCH_SIZE = 4;

    // Bit width needed to index 'count' items; never below 1 so a single-entry
    // configuration still yields a legal vector.
    function automatic int width_of(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/axis_batch_receiver_if.sv
// -----------------------------------------------------------------------------
// axis_batch_receiver_if
// AXI-Stream character beat channel feeding the batch receiver.
//   S_AXIS_TDATA  : character beat (CHAR_LEN bits)
//   S_AXIS_TVALID : beat valid
//   S_AXIS_TLAST  : last beat of a batch
//   S_AXIS_TREADY : receiver accepts a beat
// Modports: master (stream source), slave (receiver).
// -----------------------------------------------------------------------------
interface axis_batch_receiver_if
    import axis_batch_receiver_pkg::*;
#(
    parameter int CHAR_LEN = TRAIN_CHAR_LEN
);
    logic [CHAR_LEN-1:0] S_AXIS_TDATA;
    logic                S_AXIS_TVALID;
    logic                S_AXIS_TLAST;
    logic                S_AXIS_TREADY;

    modport master (
        output S_AXIS_TDATA,
        output S_AXIS_TVALID,
        output S_AXIS_TLAST,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TDATA,
        input  S_AXIS_TVALID,
        input  S_AXIS_TLAST,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/axis_batch_receiver_char_buffer.sv
// -----------------------------------------------------------------------------
// char_buffer
// Character store for one batch: one write port and an N-character read slice
// selected by sample index. Optional one-cycle zero-fill of every entry at or
// above fill_from (HAS_CLR=1); contents are never reset.
//   clk       : clock
//   we        : write enable
//   waddr     : write address (character index)
//   wdata     : character to write
//   fill_en   : zero-fill request (ignored when HAS_CLR=0)
//   fill_from : first entry to zero
//   rd_sample : sample index for the read slice
//   rdata     : N characters of sample rd_sample, char j at [j*CHAR_LEN +: CHAR_LEN]
// -----------------------------------------------------------------------------
module char_buffer
    import axis_batch_receiver_pkg::*;
#(
    parameter int CHAR_LEN   = TRAIN_CHAR_LEN,
    parameter int N          = TRAIN_N,
    parameter int BATCH_SIZE = TRAIN_BATCH_SIZE,
    parameter bit HAS_CLR    = 1'b0,
    localparam int DEPTH     = BATCH_SIZE * N,
    localparam int AW        = width_of(DEPTH),
    localparam int IW        = width_of(BATCH_SIZE)
)(
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [CHAR_LEN-1:0]   wdata,
    input  logic                  fill_en,
    input  logic [AW-1:0]         fill_from,
    input  logic [IW-1:0]         rd_sample,
    output logic [N*CHAR_LEN-1:0] rdata
);

    logic [CHAR_LEN-1:0] mem [DEPTH];

    // The write of the current beat wins over the zero-fill, so the beat that
    // triggers the fill still lands at its own address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we && (waddr == AW'(i))) begin
                mem[i] <= wdata;
            end else if (HAS_CLR && fill_en && (AW'(i) >= fill_from)) begin
                mem[i] <= '0;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < N; j++) begin
            rdata[j*CHAR_LEN +: CHAR_LEN] = mem[AW'(int'(rd_sample) * N + j)];
        end
    end

endmodule

// File: rtl/axis_batch_receiver.sv
// -----------------------------------------------------------------------------
// axis_batch_receiver
// Collects BATCH_SIZE*N character beats from an AXI-Stream source into a
// buffer (RECV), then presents them one sample of N characters at a time,
// advancing on 'next' (FULL). After the last sample the block refills.
// Optional macro AXIS_TLAST_CHECK_EN: checks TLAST against the beat count,
// raises sticky err_len on a mismatch and zero-fills a short batch.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   clr           : synchronous soft clear (priority over beats and next)
//   s_axis        : AXI-Stream slave (TDATA/TVALID/TLAST in, TREADY out)
//   next          : consumer pulse requesting the next sample
//   q             : current sample, char j at [j*CHAR_LEN +: CHAR_LEN]
//   q_valid       : q holds a valid sample
//   q_idx         : index of the sample on q
//   err_len       : sticky TLAST position error (0 without the macro)
// -----------------------------------------------------------------------------
module axis_batch_receiver
    import axis_batch_receiver_pkg::*;
#(
    parameter int CHAR_LEN   = TRAIN_CHAR_LEN,
    parameter int N          = TRAIN_N,
    parameter int BATCH_SIZE = TRAIN_BATCH_SIZE,
    localparam int TOTAL     = BATCH_SIZE * N,
    localparam int CW        = width_of(TOTAL),
    localparam int IW        = width_of(BATCH_SIZE)
)(
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  clr,
    axis_batch_receiver_if.slave  s_axis,
    input  logic                  next,
    output logic [N*CHAR_LEN-1:0] q,
    output logic                  q_valid,
    output logic [IW-1:0]         q_idx,
    output logic                  err_len
);

    localparam logic [0:0] ST_RECV = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BATCH_SIZE - 1);

    logic [0:0]    state;
    logic [CW-1:0] wr_cnt;
    logic          beat;
    logic          final_beat;
    logic          batch_done;
    logic          fill_en;

    assign s_axis.S_AXIS_TREADY = (state == ST_RECV);
    assign q_valid              = (state == ST_FULL);

    assign beat       = s_axis.S_AXIS_TVALID && (state == ST_RECV);
    assign final_beat = beat && (wr_cnt == LAST_CNT);

`ifdef AXIS_TLAST_CHECK_EN
    localparam bit HAS_CLR = 1'b1;

    logic early_last;
    logic missing_last;

    assign early_last   = beat && s_axis.S_AXIS_TLAST && (wr_cnt != LAST_CNT);
    assign missing_last = final_beat && !s_axis.S_AXIS_TLAST;
    assign batch_done   = final_beat || early_last;
    assign fill_en      = early_last && !clr;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_len <= 1'b0;
        end else if (clr) begin
            err_len <= 1'b0;
        end else if (early_last || missing_last) begin
            err_len <= 1'b1;
        end
    end
`else
    localparam bit HAS_CLR = 1'b0;

    // TLAST carries no meaning here; the batch boundary is the beat count.
    logic unused_tlast;
    assign unused_tlast = s_axis.S_AXIS_TLAST;
    assign batch_done   = final_beat;
    assign fill_en      = 1'b0;
    assign err_len      = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state  <= ST_RECV;
            wr_cnt <= '0;
            q_idx  <= '0;
        end else if (clr) begin
            state  <= ST_RECV;
            wr_cnt <= '0;
            q_idx  <= '0;
        end else begin
            case (state)
                ST_RECV: begin
                    if (batch_done) begin
                        state <= ST_FULL;
                    end else if (beat) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                ST_FULL: begin
                    if (next) begin
                        if (q_idx == LAST_IDX) begin
                            state  <= ST_RECV;
                            wr_cnt <= '0;
                            q_idx  <= '0;
                        end else begin
                            q_idx <= q_idx + 1'b1;
                        end
                    end
                end
                default: state <= ST_RECV;
            endcase
        end
    end

    char_buffer #(
        .CHAR_LEN   (CHAR_LEN),
        .N          (N),
        .BATCH_SIZE (BATCH_SIZE),
        .HAS_CLR    (HAS_CLR)
    ) u_char_buffer (
        .clk       (ACLK),
        .we        (beat && !clr),
        .waddr     (wr_cnt),
        .wdata     (s_axis.S_AXIS_TDATA),
        .fill_en   (fill_en),
        .fill_from (wr_cnt + 1'b1),
        .rd_sample (q_idx),
        .rdata     (q)
    );

endmodule

// File: tb/tb_axis_batch_receiver.sv
module tb_axis_batch_receiver;
    import axis_batch_receiver_pkg::*;

    localparam int CL    = TRAIN_CHAR_LEN;
    localparam int NN    = TRAIN_N;
    localparam int BS    = TRAIN_BATCH_SIZE;
    localparam int TOTAL = NN * BS;
    localparam int IW    = width_of(BS);

    logic              ACLK    = 1'b0;
    logic              ARESETN = 1'b0;
    logic              clr     = 1'b0;
    logic              next    = 1'b0;
    logic [NN*CL-1:0]  q;
    logic              q_valid;
    logic [IW-1:0]     q_idx;
    logic              err_len;

    int vectors     = 0;
    int miscompares = 0;

    axis_batch_receiver_if #(.CHAR_LEN(CL)) s_axis_if ();

    axis_batch_receiver dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clr     (clr),
        .s_axis  (s_axis_if),
        .next    (next),
        .q       (q),
        .q_valid (q_valid),
        .q_idx   (q_idx),
        .err_len (err_len)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_beat(input logic [CL-1:0] data, input logic last);
        s_axis_if.S_AXIS_TVALID = 1'b1;
        s_axis_if.S_AXIS_TDATA  = data;
        s_axis_if.S_AXIS_TLAST  = last;
        tick();
        s_axis_if.S_AXIS_TVALID = 1'b0;
        s_axis_if.S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic pulse_next();
        next = 1'b1;
        tick();
        next = 1'b0;
    endtask

    initial begin
        int b;
        s_axis_if.S_AXIS_TVALID = 1'b0;
        s_axis_if.S_AXIS_TLAST  = 1'b0;
        s_axis_if.S_AXIS_TDATA  = '0;

        // Reset state
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_tready", s_axis_if.S_AXIS_TREADY, 1);
        check("rst_q_valid", q_valid, 0);
        check("rst_q_idx", q_idx, 0);
        check("rst_err_len", err_len, 0);
        ARESETN = 1'b1;
        tick();

        // next ignored while receiving
        pulse_next();
        check("recv_next_q_idx", q_idx, 0);
        check("recv_next_q_valid", q_valid, 0);

        // Batch 1: 0x01..0x10, TLAST on last beat
        for (int i = 0; i < TOTAL; i++) begin
            if (i == TOTAL - 1) check("b1_tready_before_last", s_axis_if.S_AXIS_TREADY, 1);
            send_beat(CL'(i + 1), i == TOTAL - 1);
        end
        check("b1_tready_after", s_axis_if.S_AXIS_TREADY, 0);
        check("b1_q_valid", q_valid, 1);
        check("b1_q_idx", q_idx, 0);
        check("b1_q_s0", q, 32'h04030201);

        for (int k = 1; k < BS; k++) begin
            pulse_next();
            check("b1_next_q_idx", q_idx, k);
            check("b1_next_char0", q[CL-1:0], CL'(k * NN + 1));
        end
        check("b1_q_s3", q, 32'h100F0E0D);

        pulse_next();
        check("b1_drain_q_valid", q_valid, 0);
        check("b1_drain_tready", s_axis_if.S_AXIS_TREADY, 1);
        check("b1_drain_q_idx", q_idx, 0);
        check("b1_buffer_kept", q, 32'h04030201);

        // Batch 2: 0x80+k overwrites batch 1
        for (int i = 0; i < TOTAL; i++) send_beat(CL'(8'h80 + i), i == TOTAL - 1);
        check("b2_q_valid", q_valid, 1);
        check("b2_char0", q[CL-1:0], 8'h80);
        check("b2_q_s0", q, 32'h83828180);
        repeat (BS) pulse_next();
        check("b2_drain_q_valid", q_valid, 0);

        // TVALID toggling: idle cycles carry junk data that must not be taken
        b = 0;
        while (b < TOTAL) begin
            s_axis_if.S_AXIS_TVALID = 1'b1;
            s_axis_if.S_AXIS_TDATA  = CL'(b + 1);
            s_axis_if.S_AXIS_TLAST  = (b == TOTAL - 1);
            tick();
            b++;
            s_axis_if.S_AXIS_TVALID = 1'b0;
            s_axis_if.S_AXIS_TLAST  = 1'b0;
            if (b == 8) check("tog_mid_q_valid", q_valid, 0);
            if (b < TOTAL) begin
                s_axis_if.S_AXIS_TDATA = 8'hEE;
                tick();
            end
        end
        check("tog_q_valid", q_valid, 1);
        check("tog_tready", s_axis_if.S_AXIS_TREADY, 0);
        check("tog_q_s0", q, 32'h04030201);
        pulse_next();
        check("tog_q_s1", q, 32'h08070605);
        repeat (BS - 1) pulse_next();
        check("tog_drain_q_valid", q_valid, 0);

        // Reset during a partial fill discards it
        for (int i = 0; i < 5; i++) send_beat(CL'(8'hA0 + i), 1'b0);
        #2 ARESETN = 1'b0;
        #1;
        check("midrst_tready", s_axis_if.S_AXIS_TREADY, 1);
        check("midrst_q_valid", q_valid, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int i = 0; i < TOTAL; i++) send_beat(CL'(8'h41 + i), i == TOTAL - 1);
        check("midrst_full_q_valid", q_valid, 1);
        check("midrst_q_s0", q, 32'h44434241);
        check("midrst_err_len", err_len, 0);

        // clr in FULL wins over a simultaneous next
        clr  = 1'b1;
        next = 1'b1;
        tick();
        clr  = 1'b0;
        next = 1'b0;
        check("clr_full_q_valid", q_valid, 0);
        check("clr_full_q_idx", q_idx, 0);
        check("clr_full_tready", s_axis_if.S_AXIS_TREADY, 1);

        // clr during a partial fill wins over a simultaneous beat
        for (int i = 0; i < 3; i++) send_beat(CL'(8'hC0 + i), 1'b0);
        clr = 1'b1;
        send_beat(8'hFF, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < TOTAL; i++) send_beat(CL'(8'h11 + i), i == TOTAL - 1);
        check("clr_fill_q_valid", q_valid, 1);
        check("clr_fill_q_s0", q, 32'h14131211);
        pulse_next();
        check("clr_fill_q_s1", q, 32'h18171615);
        repeat (BS - 1) pulse_next();
        check("clr_fill_drain_q_valid", q_valid, 0);

`ifdef AXIS_TLAST_CHECK_EN
        // Early TLAST on the third beat: error, zero-fill, FULL
        for (int i = 0; i < 3; i++) send_beat(CL'(8'h21 + i), i == 2);
        check("tl_err_len", err_len, 1);
        check("tl_q_valid", q_valid, 1);
        check("tl_tready", s_axis_if.S_AXIS_TREADY, 0);
        check("tl_q_s0", q, 32'h00232221);
        pulse_next();
        check("tl_q_s1", q, 32'h00000000);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("tl_clr_err_len", err_len, 0);
        check("tl_clr_q_valid", q_valid, 0);
        check("tl_clr_tready", s_axis_if.S_AXIS_TREADY, 1);
`else
        // Early TLAST is ignored; only the count ends the batch
        for (int i = 0; i < 3; i++) send_beat(CL'(8'h21 + i), i == 2);
        check("tl_ign_q_valid", q_valid, 0);
        check("tl_ign_tready", s_axis_if.S_AXIS_TREADY, 1);
        check("tl_ign_err_len", err_len, 0);
        for (int i = 3; i < TOTAL; i++) send_beat(CL'(8'h21 + i), 1'b0);
        check("tl_ign_full_q_valid", q_valid, 1);
        check("tl_ign_q_s0", q, 32'h24232221);
        check("tl_ign_full_err_len", err_len, 0);
        repeat (BS) pulse_next();
        check("tl_ign_drain_q_valid", q_valid, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
